// File: rtl/arbitrated_line_adaptor_pkg.sv
// Shared types and elaboration helpers for the arbitrated cache-line adaptor.
package arbitrated_line_adaptor_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_e;

    function automatic int beats_f(input int line_width, input int burst_width);
        return line_width / burst_width;
    endfunction

    function automatic int offset_f(input int line_width);
        return $clog2(line_width / 8);
    endfunction

    // A single-entry index still needs one bit of storage.
    function automatic int idx_width_f(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/arbitrated_line_adaptor_if.sv
// Bundle of cache-side request ports and the burst memory port.
interface arbitrated_line_adaptor_if #(
    parameter int NUM_PORTS   = 2,
    parameter int LINE_WIDTH  = 256,
    parameter int BURST_WIDTH = 64,
    parameter int ADDR_WIDTH  = 32
);
    logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] port_address_i;
    logic [NUM_PORTS-1:0][LINE_WIDTH-1:0] port_line_i;
    logic [NUM_PORTS-1:0]                 port_read_i;
    logic [NUM_PORTS-1:0]                 port_write_i;
    logic [LINE_WIDTH-1:0]                port_line_o;
    logic [NUM_PORTS-1:0]                 port_resp_o;
    logic [ADDR_WIDTH-1:0]                address_o;
    logic [BURST_WIDTH-1:0]               burst_o;
    logic [BURST_WIDTH-1:0]               burst_i;
    logic                                 read_o;
    logic                                 write_o;
    logic                                 resp_i;

    modport master (
        output port_address_i, port_line_i, port_read_i, port_write_i, burst_i, resp_i,
        input  port_line_o, port_resp_o, address_o, burst_o, read_o, write_o
    );

    modport slave (
        input  port_address_i, port_line_i, port_read_i, port_write_i, burst_i, resp_i,
        output port_line_o, port_resp_o, address_o, burst_o, read_o, write_o
    );
endinterface

// File: rtl/arbitrated_line_adaptor_rr_arbiter.sv
// Round-robin arbiter: searches from the port after the last served one.
module rr_arbiter
    import arbitrated_line_adaptor_pkg::*;
#(
    parameter  int NUM_PORTS = 2,
    localparam int IDX_W     = idx_width_f(NUM_PORTS)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NUM_PORTS-1:0] req,
    input  logic                 update_en,
    input  logic [IDX_W-1:0]     update_idx,
    output logic [NUM_PORTS-1:0] grant,
    output logic [IDX_W-1:0]     grant_idx
);

    logic [IDX_W-1:0] last_r;

    // Pick the first requester at or after last_r + 1, wrapping around.
    always_comb begin
        int   cand;
        logic found;
        logic hit;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            cand        = (int'(last_r) + 1 + i) % NUM_PORTS;
            hit         = ~found & req[cand];
            grant[cand] = hit;
            grant_idx   = hit ? IDX_W'(cand) : grant_idx;
            found       = found | hit;
        end
    end

    // Reset to the last port so that port 0 wins the first arbitration.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_r <= IDX_W'(NUM_PORTS - 1);
        end else if (update_en) begin
            last_r <= update_idx;
        end
    end

endmodule

// File: rtl/arbitrated_line_adaptor.sv
// Arbitrates whole-line requests from several cache ports onto one burst memory
// port, splitting writes into beats and assembling read beats into a line.
module arbitrated_line_adaptor
    import arbitrated_line_adaptor_pkg::*;
#(
    parameter int NUM_PORTS   = 2,
    parameter int LINE_WIDTH  = 256,
    parameter int BURST_WIDTH = 64,
    parameter int ADDR_WIDTH  = 32
) (
    input  logic                     clk,
    input  logic                     reset_n,
    arbitrated_line_adaptor_if.slave bus
);

    localparam int BEATS  = beats_f(LINE_WIDTH, BURST_WIDTH);
    localparam int OFFSET = offset_f(LINE_WIDTH);
    localparam int IDX_W  = idx_width_f(NUM_PORTS);
    localparam int CNT_W  = idx_width_f(BEATS);
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~ADDR_WIDTH'((64'd1 << OFFSET) - 64'd1);
    localparam logic [CNT_W-1:0]      LAST_BEAT = CNT_W'(BEATS - 1);

    state_e                 state_r;
    state_e                 state_next_s;
    logic [NUM_PORTS-1:0]   req_s;
    logic [NUM_PORTS-1:0]   grant_s;
    logic [IDX_W-1:0]       grant_idx_s;
    logic [IDX_W-1:0]       gidx_r;
    logic [ADDR_WIDTH-1:0]  addr_r;
    logic [LINE_WIDTH-1:0]  line_r;
    logic [BURST_WIDTH-1:0] burst_r;
    logic [CNT_W-1:0]       cnt_r;
    logic [CNT_W-1:0]       cnt_next_s;
    logic                   last_beat_s;
    logic                   read_r;
    logic                   write_r;
    logic [NUM_PORTS-1:0]   resp_r;
    logic                   read_next_s;
    logic                   write_next_s;
    logic [NUM_PORTS-1:0]   resp_next_s;

    assign req_s       = bus.port_read_i | bus.port_write_i;
    assign last_beat_s = (cnt_r == LAST_BEAT);
    assign cnt_next_s  = cnt_r + CNT_W'(1'b1);

    rr_arbiter #(
        .NUM_PORTS (NUM_PORTS)
    ) u_arb (
        .clk        (clk),
        .reset_n    (reset_n),
        .req        (req_s),
        .update_en  (state_r == DONE),
        .update_idx (gidx_r),
        .grant      (grant_s),
        .grant_idx  (grant_idx_s)
    );

    // Next-state decode; outputs are derived from the next state and registered.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (|req_s) begin
                    if (|(bus.port_write_i & grant_s)) begin
                        state_next_s = WRITE;
                    end else begin
                        state_next_s = READ;
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            READ, WRITE: begin
                if (bus.resp_i && last_beat_s) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = state_r;
                end
            end
            DONE:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
        read_next_s  = (state_next_s == READ);
        write_next_s = (state_next_s == WRITE);
        resp_next_s  = (state_next_s == DONE) ? (NUM_PORTS'(1'b1) << gidx_r) : '0;
    end

    // State and handshake output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
            read_r  <= 1'b0;
            write_r <= 1'b0;
            resp_r  <= '0;
        end else begin
            state_r <= state_next_s;
            read_r  <= read_next_s;
            write_r <= write_next_s;
            resp_r  <= resp_next_s;
        end
    end

    // Request latch, beat counter and line/beat data path; gaps hold everything.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            gidx_r  <= '0;
            addr_r  <= '0;
            line_r  <= '0;
            burst_r <= '0;
            cnt_r   <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (|req_s) begin
                        gidx_r  <= grant_idx_s;
                        addr_r  <= bus.port_address_i[grant_idx_s] & LINE_MASK;
                        line_r  <= bus.port_line_i[grant_idx_s];
                        burst_r <= bus.port_line_i[grant_idx_s][BURST_WIDTH-1:0];
                        cnt_r   <= '0;
                    end
                end
                READ: begin
                    if (bus.resp_i) begin
                        line_r[cnt_r*BURST_WIDTH +: BURST_WIDTH] <= bus.burst_i;
                        cnt_r                                    <= cnt_next_s;
                    end
                end
                WRITE: begin
                    if (bus.resp_i) begin
                        cnt_r <= cnt_next_s;
                        if (!last_beat_s) begin
                            burst_r <= line_r[cnt_next_s*BURST_WIDTH +: BURST_WIDTH];
                        end
                    end
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

    assign bus.read_o      = read_r;
    assign bus.write_o     = write_r;
    assign bus.port_resp_o = resp_r;
    assign bus.port_line_o = line_r;
    assign bus.address_o   = addr_r;
    assign bus.burst_o     = burst_r;

endmodule

// File: tb/tb_arbitrated_line_adaptor.sv
// Self-checking bench: vector table plus hand sequences, with a response scoreboard.
module tb_arbitrated_line_adaptor;

    localparam int NP  = 2;
    localparam int LW  = 256;
    localparam int BW  = 64;
    localparam int AW  = 32;
    localparam int BW2 = 32;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    arbitrated_line_adaptor_if #(.NUM_PORTS(NP), .LINE_WIDTH(LW), .BURST_WIDTH(BW),  .ADDR_WIDTH(AW)) bus  ();
    arbitrated_line_adaptor_if #(.NUM_PORTS(NP), .LINE_WIDTH(LW), .BURST_WIDTH(BW2), .ADDR_WIDTH(AW)) bus2 ();

    arbitrated_line_adaptor #(.NUM_PORTS(NP), .LINE_WIDTH(LW), .BURST_WIDTH(BW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus.slave));
    arbitrated_line_adaptor #(.NUM_PORTS(NP), .LINE_WIDTH(LW), .BURST_WIDTH(BW2), .ADDR_WIDTH(AW)) dut2 (
        .clk(clk), .reset_n(reset_n), .bus(bus2.slave));

    typedef struct {
        int          port;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] exp_addr;
        logic [255:0] data;
        logic [7:0]  pat;
    } vec_t;

    typedef struct {
        int           port;
        bit           wr;
        logic [255:0] line;
    } sb_t;

    sb_t          sb_q[$];
    int           checks = 0;
    int           errors = 0;
    vec_t         tbl[7];
    logic [255:0] exp2;
    int           w;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [255:0] mk_line(input logic [63:0] s);
        return {s + 64'd3, s + 64'd2, s + 64'd1, s};
    endfunction

    // Waits for the burst to start, plays the memory side, checks the done pulse.
    task automatic serve(input vec_t v, output int waited);
        int beat;
        int cyc;
        logic [63:0] slice;
        waited = 0;
        while (!(bus.read_o || bus.write_o) && waited < 20) begin
            step();
            waited++;
        end
        if (!(bus.read_o || bus.write_o)) begin
            check("burst_start_timeout", 0, 1);
            return;
        end
        check("address_o", bus.address_o, v.exp_addr);
        beat = 0;
        cyc  = 0;
        while (beat < LW / BW && cyc < 64) begin
            check(v.wr ? "write_burst_held" : "read_burst_held",
                  {bus.port_resp_o, bus.write_o, bus.read_o}, {2'b00, v.wr ? 2'b10 : 2'b01});
            bus.resp_i = v.pat[cyc % 8];
            if (bus.resp_i) begin
                slice       = v.data[beat*BW +: BW];
                bus.burst_i = slice;
                if (v.wr) check("burst_o_beat", bus.burst_o, slice);
                beat++;
            end else begin
                bus.burst_i = {$urandom(), $urandom()};
            end
            step();
            cyc++;
        end
        bus.resp_i = 1'b0;
        check("resp_timing", bus.port_resp_o, 2'b01 << v.port);
        check("done_bus_idle", {bus.read_o, bus.write_o}, 2'b00);
    endtask

    task automatic run_txn(input vec_t v);
        int waited;
        bus.resp_i  = 1'b1;
        bus.burst_i = {$urandom(), $urandom()};
        step();
        bus.resp_i = 1'b0;
        bus.port_address_i[v.port] = v.addr;
        bus.port_line_i[v.port]    = v.wr ? v.data : ~v.data;
        bus.port_write_i[v.port]   = v.wr;
        bus.port_read_i[v.port]    = !v.wr;
        sb_q.push_back('{v.port, v.wr, v.data});
        step();
        serve(v, waited);
        check("grant_latency", waited, 0);
        step();
        bus.port_read_i[v.port]  = 1'b0;
        bus.port_write_i[v.port] = 1'b0;
        check("resp_one_cycle", bus.port_resp_o, 0);
    endtask

    task automatic arb_serve(input int port, input logic [255:0] data);
        vec_t v;
        int   waited;
        logic [31:0] a;
        a = (port == 0) ? 32'h0000_0100 : 32'h0000_0200;
        v = '{port, 1'b0, a, a, data, 8'hFF};
        serve(v, waited);
        check("arb_grant_wait", waited, 0);
        step();
        bus.port_read_i[port] = 1'b0;
    endtask

    // Scoreboard: every done pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        sb_t e;
        if (reset_n === 1'b1 && bus.port_resp_o !== '0) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected_resp: got %b, expected no response", bus.port_resp_o);
            end else begin
                e = sb_q.pop_front();
                check("sb_resp_port", bus.port_resp_o, 2'b01 << e.port);
                if (!e.wr) check("sb_read_line", bus.port_line_o, e.line);
            end
        end
    end

    // A port must never present read and write together.
    always @(posedge clk) begin
        if (reset_n === 1'b1) begin
            assert ((bus.port_read_i & bus.port_write_i) == '0)
                else $error("port asserted read and write together");
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish, %0d errors so far", errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        tbl[0] = '{0, 1'b0, 32'h0000_0040, 32'h0000_0040,
                   {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                    64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}, 8'hFF};
        tbl[1] = '{1, 1'b1, 32'h0000_0080, 32'h0000_0080,
                   {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                    64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA}, 8'hFF};
        tbl[2] = '{0, 1'b0, 32'h0000_1000, 32'h0000_1000, mk_line(64'h0123_4567_89AB_CDEF), 8'h59};
        tbl[3] = '{1, 1'b0, 32'h1234_5678, 32'h1234_5660, mk_line(64'hFEED_0000_0000_0010), 8'hAA};
        tbl[4] = '{0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFE0, mk_line(64'h5A5A_0000_1111_0000), 8'h6D};
        tbl[5] = '{1, 1'b1, 32'h0000_0020, 32'h0000_0020, mk_line(64'h0BAD_CAFE_0000_0100), 8'h33};
        tbl[6] = '{0, 1'b0, 32'h0000_0040, 32'h0000_0040, mk_line(64'h7777_0000_0000_0001), 8'hFF};

        reset_n = 1'b0;
        bus.port_address_i = '0;  bus.port_line_i = '0;  bus.port_read_i = '0;
        bus.port_write_i   = '0;  bus.burst_i     = '0;  bus.resp_i      = 1'b0;
        bus2.port_address_i = '0; bus2.port_line_i = '0; bus2.port_read_i = '0;
        bus2.port_write_i   = '0; bus2.burst_i     = '0; bus2.resp_i      = 1'b0;
        repeat (2) step();
        check("rst_handshake", {bus.read_o, bus.write_o, bus.port_resp_o}, 0);
        check("rst_address_burst", {bus.address_o, bus.burst_o}, 0);
        check("rst_line", bus.port_line_o, 0);
        reset_n = 1'b1;
        step();

        // Both ports request right after reset, then fairness with a re-request.
        bus.port_address_i[0] = 32'h0000_0100;
        bus.port_address_i[1] = 32'h0000_0200;
        bus.port_read_i = 2'b11;
        sb_q.push_back('{0, 1'b0, mk_line(64'h100)});
        sb_q.push_back('{1, 1'b0, mk_line(64'h200)});
        step();
        arb_serve(0, mk_line(64'h100));
        step();
        bus.port_read_i[0] = 1'b1;
        sb_q.push_back('{0, 1'b0, mk_line(64'h300)});
        arb_serve(1, mk_line(64'h200));
        step();
        arb_serve(0, mk_line(64'h300));
        step();
        bus.port_read_i = 2'b11;
        sb_q.push_back('{1, 1'b0, mk_line(64'h400)});
        sb_q.push_back('{0, 1'b0, mk_line(64'h500)});
        step();
        arb_serve(1, mk_line(64'h400));
        step();
        arb_serve(0, mk_line(64'h500));

        for (int i = 0; i < 6; i++) run_txn(tbl[i]);

        // Write aborted by reset after two of four beats.
        step();
        bus.port_line_i[1]  = mk_line(64'h9999_0000_0000_0000);
        bus.port_write_i[1] = 1'b1;
        step();
        check("abort_write_started", bus.write_o, 1);
        bus.resp_i = 1'b1;
        step();
        step();
        bus.resp_i = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        check("abort_async_drop", {bus.read_o, bus.write_o, bus.port_resp_o}, 0);
        check("abort_regs_cleared", {bus.address_o, bus.burst_o}, 0);
        check("abort_line_cleared", bus.port_line_o, 0);
        bus.port_write_i[1] = 1'b0;
        step();
        check("abort_held_idle", {bus.read_o, bus.write_o}, 0);
        reset_n = 1'b1;
        run_txn(tbl[6]);

        // Eight-beat variant: 32-bit beats, unaligned address.
        bus2.port_address_i[0] = 32'h1234_5678;
        bus2.port_read_i[0]    = 1'b1;
        step();
        check("bw32_address", bus2.address_o, 32'h1234_5660);
        for (int i = 0; i < 8; i++) begin
            check("bw32_read_held", {bus2.port_resp_o, bus2.read_o}, 3'b001);
            exp2[i*BW2 +: BW2] = 32'hA000_0000 + 32'(i);
            bus2.resp_i  = 1'b1;
            bus2.burst_i = 32'hA000_0000 + 32'(i);
            step();
        end
        bus2.resp_i = 1'b0;
        check("bw32_resp_t9", bus2.port_resp_o, 2'b01);
        check("bw32_line", bus2.port_line_o, exp2);
        step();
        bus2.port_read_i[0] = 1'b0;
        check("bw32_resp_one_cycle", bus2.port_resp_o, 0);

        step();
        check("sb_drained", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/arbitrated_line_adaptor.md
Name: arbitrated_line_adaptor

Overview:
N-port successor to the single-port cacheline adaptor. It sits between several last-level cache ports (e.g. I-cache and D-cache) and one burst-mode physical memory port. Each request is a whole cache line. It round-robin arbitrates among ports, latches the winning line request, and splits or assembles it into LINE_WIDTH/BURST_WIDTH memory beats. Beats may be non-consecutive; the block tolerates gaps.

Parameters:
NUM_PORTS, 2, number of cache-side request ports (>=1)
LINE_WIDTH, 256, cache line width in bits
BURST_WIDTH, 64, memory beat width in bits; LINE_WIDTH must be an integer multiple
ADDR_WIDTH, 32, byte address width

Ports:
clk  in  1  clock; all state changes on rising edge
reset_n  in  1  asynchronous, active-low reset
port_address_i  in  NUM_PORTS x ADDR_WIDTH  per-port line address
port_line_i  in  NUM_PORTS x LINE_WIDTH  per-port write line
port_read_i  in  NUM_PORTS  per-port line read request, held until its resp
port_write_i  in  NUM_PORTS  per-port line write request, held until its resp
port_line_o  out  LINE_WIDTH  shared read-line bus, valid only while a port_resp_o bit is high
port_resp_o  out  NUM_PORTS  one-cycle done pulse, one-hot
address_o  out  ADDR_WIDTH  line-aligned memory address
burst_o  out  BURST_WIDTH  current write beat
burst_i  in  BURST_WIDTH  read beat, valid when resp_i=1
read_o  out  1  memory read, held for the whole burst
write_o  out  1  memory write, held for the whole burst
resp_i  in  1  memory beat handshake, one beat per high cycle

Behaviour:
- BEATS = LINE_WIDTH/BURST_WIDTH. OFFSET = log2(LINE_WIDTH/8).
- Reset (async, any state): state=IDLE; read_o, write_o and port_resp_o go to 0 immediately. address_o, burst_o, port_line_o and the beat counter go to 0. The round-robin pointer is set so port 0 has the highest priority. An in-flight burst is abandoned.
- States: IDLE, READ, WRITE, DONE. All outputs are registered or Moore-decoded from state.
- IDLE:
  - A port requests when read_i|write_i is high.
  - If any port requests, grant the first requester at or after (last_grant+1) mod NUM_PORTS.
  - On grant, latch the port index, address_o = {addr[ADDR_WIDTH-1:OFFSET], OFFSET'b0}, and the write line. Clear the beat counter.
  - Go to WRITE if that port's write_i is high, else READ. If both are high on one port, write wins (illegal; flag with a bench assertion).
- READ: read_o=1.
  - Each cycle resp_i=1 stores burst_i into line slice [cnt*BURST_WIDTH +: BURST_WIDTH] and increments cnt.
  - resp_i on beat BEATS-1 goes to DONE.
- WRITE: write_o=1 and burst_o = latched line slice [cnt*BURST_WIDTH +: BURST_WIDTH].
  - cnt advances on each resp_i=1.
  - The last beat goes to DONE.
- resp_i=0 cycles inside a burst hold all state (gap tolerance). resp_i in IDLE or DONE is ignored.
- DONE:
  - read_o and write_o are 0.
  - port_resp_o[granted] = 1 for exactly one cycle. port_line_o carries the assembled line (read) or is don't-care (write).
  - Update last_grant to the granted port, then go to IDLE.
- Requester contract: deassert the request in the cycle after resp, so IDLE never re-sees a served request.
- Latency: request seen in IDLE at cycle t gives read_o/write_o at t+1. With back-to-back beats, port_resp_o is at t+BEATS+1.
- The first beat can arrive at t+1, in the same cycle read_o first rises.
- Fairness: with all ports requesting continuously, grants rotate 0,1,…,N-1,0…. No port waits more than N-1 transactions.
- Non-granted ports see port_resp_o=0. Their inputs may change freely.

Decomposition:
- adaptor_pkg holds:
  - the state enum (IDLE/READ/WRITE/DONE)
  - the BEATS and OFFSET localparam functions
  - a clog2-based port-index width helper
- Sub-module rr_arbiter (parameter NUM_PORTS):
  - request vector in; one-hot grant and encoded index out
  - takes an update enable plus the index to store as last_grant
  - async active-low reset on clk/reset_n

Test Plan:
- Read port 0, address 0x0000_0040, beats 0x1111…, 0x2222…, 0x3333…, 0x4444… on consecutive cycles -> address_o=0x40; port_resp_o=2'b01 at t+5; port_line_o={0x4444…,0x3333…,0x2222…,0x1111…}.
- Write port 1, line {D,C,B,A} (64-bit words) -> write_o held; burst_o=A,B,C,D on the four resp_i cycles; port_resp_o=2'b10 one cycle after the last beat; read_o stays 0.
- Ports 0 and 1 both request reads right after reset -> port 0 served first, then port 1. Port 0 re-requests while port 1 also requests -> port 1 is not starved, and after port 1 the grant returns to port 0.
- Read with resp_i pattern 1,0,0,1,1,0,1 -> exactly four beats captured in order; line correct; resp pulse one cycle after the seventh cycle.
- Assert reset_n=0 after two of four write beats -> write_o drops asynchronously; state IDLE. After release, a new read to port 0 completes normally with counter from 0.
- Unaligned address 0x1234_5678 -> address_o=0x1234_5660 (LINE_WIDTH=256). Rerun with BURST_WIDTH=32: 8 beats, resp at t+9.
